// File: rtl/if_fetch_unit.sv
// if_fetch_unit
// Instruction fetch stage feeding the IF/ID pipeline register. It owns the
// program counter and keeps at most one request outstanding to instruction
// memory. Returned words are queued with their PC+4 in a small prefetch FIFO
// whose head is presented to IF/ID.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   freeze       IF/ID stall from the hazard unit (head is not consumed)
//   branchTaken  redirect pulse from EXE, overrides everything but rst
//   branchAddr   redirect target (word aligned)
//   imemReq      request to instruction memory
//   imemAddr     request address, held while imemReq is high
//   imemReady    request completed, imemData valid this cycle
//   imemData     returned instruction word
//   PC           PC+4 of the FIFO head (0 when empty)
//   instruction  FIFO head word (0 when empty)
//   fetchStall   FIFO empty
module if_fetch_unit #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branchTaken,
    input  logic [31:0] branchAddr,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic [31:0] imemData,
    output logic [31:0] PC,
    output logic [31:0] instruction,
    output logic        fetchStall
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    // DROP: a request is still on the bus but its data belongs to a
    // path abandoned by a redirect, so it must be swallowed on completion.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [31:0]      fetch_pc_r;
    logic [31:0]      fetch_pc_next_s;
    logic [31:0]      req_addr_r;
    logic [31:0]      req_addr_next_s;
    logic [31:0]      fifo_pc4_r  [DEPTH];
    logic [31:0]      fifo_word_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             empty_s;
    logic             pop_s;
    logic             push_s;
    logic             room_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // FIFO occupancy control: pop/push qualification and next-cycle room.
    always_comb begin
        empty_s = (count_r == {CNT_W{1'b0}});
        pop_s   = !freeze && !empty_s && !branchTaken;
        push_s  = (state_r == REQ) && imemReady && !branchTaken;
        if (branchTaken) begin
            count_next_s = {CNT_W{1'b0}};
        end else begin
            count_next_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
        // Room is judged on next-cycle occupancy so a new request is only
        // issued when its data is guaranteed a slot.
        room_s = (count_next_s < DEPTH_CNT);
    end

    // Fetch FSM next-state, request address and fetch PC update.
    always_comb begin
        state_next_s    = state_r;
        fetch_pc_next_s = fetch_pc_r;
        req_addr_next_s = req_addr_r;
        case (state_r)
            IDLE: begin
                if (branchTaken) begin
                    state_next_s    = REQ;
                    req_addr_next_s = branchAddr;
                    fetch_pc_next_s = branchAddr + 32'd4;
                end else if (room_s) begin
                    state_next_s    = REQ;
                    req_addr_next_s = fetch_pc_r;
                    fetch_pc_next_s = fetch_pc_r + 32'd4;
                end else begin
                    state_next_s    = IDLE;
                end
            end
            REQ: begin
                if (branchTaken && imemReady) begin
                    state_next_s    = REQ;
                    req_addr_next_s = branchAddr;
                    fetch_pc_next_s = branchAddr + 32'd4;
                end else if (branchTaken) begin
                    // Request cannot be withdrawn; keep it on the bus and
                    // discard its data later.
                    state_next_s    = DROP;
                    fetch_pc_next_s = branchAddr;
                end else if (imemReady) begin
                    if (room_s) begin
                        state_next_s    = REQ;
                        req_addr_next_s = fetch_pc_r;
                        fetch_pc_next_s = fetch_pc_r + 32'd4;
                    end else begin
                        state_next_s    = IDLE;
                    end
                end else begin
                    state_next_s = REQ;
                end
            end
            DROP: begin
                if (imemReady && branchTaken) begin
                    state_next_s    = REQ;
                    req_addr_next_s = branchAddr;
                    fetch_pc_next_s = branchAddr + 32'd4;
                end else if (imemReady) begin
                    // FIFO was flushed by the redirect, so room is implied.
                    state_next_s    = REQ;
                    req_addr_next_s = fetch_pc_r;
                    fetch_pc_next_s = fetch_pc_r + 32'd4;
                end else if (branchTaken) begin
                    state_next_s    = DROP;
                    fetch_pc_next_s = branchAddr;
                end else begin
                    state_next_s = DROP;
                end
            end
            default: begin
                state_next_s    = IDLE;
                fetch_pc_next_s = fetch_pc_r;
                req_addr_next_s = req_addr_r;
            end
        endcase
    end

    // FSM state, fetch PC and in-flight request address registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            fetch_pc_r <= RESET_PC;
            req_addr_r <= 32'h0;
        end else begin
            state_r    <= state_next_s;
            fetch_pc_r <= fetch_pc_next_s;
            req_addr_r <= req_addr_next_s;
        end
    end

    // Prefetch FIFO storage, pointers and occupancy; a redirect flushes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_pc4_r[i]  <= 32'h0;
                fifo_word_r[i] <= 32'h0;
            end
        end else if (branchTaken) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                fifo_pc4_r[wr_ptr_r]  <= req_addr_r + 32'd4;
                fifo_word_r[wr_ptr_r] <= imemData;
                wr_ptr_r              <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            count_r <= count_next_s;
        end
    end

    // Output view: head entry straight from storage, zeros when empty.
    always_comb begin
        imemReq  = (state_r == REQ) || (state_r == DROP);
        imemAddr = req_addr_r;
        if (empty_s) begin
            PC          = 32'h0;
            instruction = 32'h0;
            fetchStall  = 1'b1;
        end else begin
            PC          = fifo_pc4_r[rd_ptr_r];
            instruction = fifo_word_r[rd_ptr_r];
            fetchStall  = 1'b0;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit
// Self-checking bench for if_fetch_unit. A memory model answers requests with
// a chosen or random latency; a transaction-level model (queue of expected
// {PC+4, word} entries, next expected fetch address, stale-request flag)
// predicts the FIFO head, request addresses and occupancy bound.
module tb_if_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze;
    logic        branchTaken;
    logic [31:0] branchAddr;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic [31:0] imemData;
    logic [31:0] PC;
    logic [31:0] instruction;
    logic        fetchStall;

    if_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .branchTaken (branchTaken),
        .branchAddr  (branchAddr),
        .imemReq     (imemReq),
        .imemAddr    (imemAddr),
        .imemReady   (imemReady),
        .imemData    (imemData),
        .PC          (PC),
        .instruction (instruction),
        .fetchStall  (fetchStall)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // reference model state
    logic [63:0] q[$];
    logic [31:0] m_fetch;
    logic [31:0] infl_addr;
    bit          infl_stale;
    bit          prev_req;
    bit          prev_ready;
    logic [31:0] prev_addr;
    int          age;
    int          lat;
    int          fix_lat;
    // per-cycle stimulus
    bit          drv_freeze;
    bit          drv_br;
    logic [31:0] drv_baddr;
    bit          found;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hE000_0000 | a;
    endfunction

    // One clock cycle: called at a negedge, checks outputs, drives inputs,
    // advances the model, returns at the following negedge.
    task automatic step();
        bit          new_req;
        bit          rdy;
        bit          ok;
        logic [31:0] exp_pc;
        logic [31:0] exp_ins;
        if (q.size() == 0) begin
            exp_pc  = 32'h0;
            exp_ins = 32'h0;
        end else begin
            exp_pc  = q[0][63:32];
            exp_ins = q[0][31:0];
        end
        check_eq("stall", 32'(fetchStall), 32'(q.size() == 0));
        check_eq("pc", PC, exp_pc);
        check_eq("instr", instruction, exp_ins);
        if (prev_req && !prev_ready) begin
            check_eq("req_held", 32'(imemReq), 32'd1);
            if (imemReq) check_eq("addr_stable", imemAddr, prev_addr);
        end
        new_req = imemReq && (!prev_req || prev_ready);
        if (new_req) begin
            check_eq("req_addr", imemAddr, m_fetch);
            infl_addr  = m_fetch;
            infl_stale = 1'b0;
            m_fetch    = m_fetch + 32'd4;
            age        = 0;
            lat        = (fix_lat >= 0) ? fix_lat : int'($urandom_range(3));
        end
        if (imemReq) begin
            ok = (q.size() + (infl_stale ? 0 : 1)) <= DEPTH;
            check_eq("room", 32'(ok), 32'd1);
        end
        rdy         = imemReq && (age >= lat);
        imemReady   = rdy;
        imemData    = rdy ? mem_word(imemAddr) : $urandom();
        freeze      = drv_freeze;
        branchTaken = drv_br;
        branchAddr  = drv_br ? drv_baddr : ($urandom() & 32'hFFFF_FFFC);
        if (drv_br) begin
            q.delete();
            m_fetch = drv_baddr;
            if (imemReq) infl_stale = 1'b1;
        end else begin
            if (!drv_freeze && q.size() > 0) void'(q.pop_front());
            if (rdy && !infl_stale) q.push_back({infl_addr + 32'd4, mem_word(infl_addr)});
        end
        if (imemReq && !rdy) age++;
        prev_req   = imemReq;
        prev_ready = rdy;
        prev_addr  = imemAddr;
        @(negedge clk);
    endtask

    // Reset with random inputs, check reset values, release and check the
    // first request. Returns at a negedge.
    task automatic do_reset();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            freeze      = 1'($urandom_range(1));
            branchTaken = 1'($urandom_range(1));
            branchAddr  = $urandom() & 32'hFFFF_FFFC;
            imemReady   = 1'($urandom_range(1));
            imemData    = $urandom();
            #1;
            check_eq("rst_req", 32'(imemReq), 32'd0);
            check_eq("rst_addr", imemAddr, 32'h0);
            check_eq("rst_pc", PC, 32'h0);
            check_eq("rst_instr", instruction, 32'h0);
            check_eq("rst_stall", 32'(fetchStall), 32'd1);
            @(negedge clk);
        end
        freeze      = 1'b0;
        branchTaken = 1'b0;
        imemReady   = 1'b0;
        rst         = 1'b1;
        q.delete();
        m_fetch    = RESET_PC;
        prev_req   = 1'b0;
        prev_ready = 1'b0;
        infl_stale = 1'b0;
        age        = 0;
        @(negedge clk);
        check_eq("rel_req", 32'(imemReq), 32'd1);
        check_eq("rel_addr", imemAddr, RESET_PC);
    endtask

    initial begin
        freeze      = 1'b0;
        branchTaken = 1'b0;
        branchAddr  = 32'h0;
        imemReady   = 1'b0;
        imemData    = 32'h0;
        drv_freeze  = 1'b0;
        drv_br      = 1'b0;
        drv_baddr   = 32'h0;
        fix_lat     = 0;
        lat         = 0;
        #2;
        do_reset();

        // zero-wait stream: one instruction per cycle after the first fill
        fix_lat = 0;
        step();
        for (int i = 0; i < 12; i++) begin
            check_eq("stream_stall", 32'(fetchStall), 32'd0);
            check_eq("stream_pc", PC, 32'((i + 1) * 4));
            step();
        end

        // backpressure: FIFO fills, request drops, then streaming resumes
        drv_freeze = 1'b1;
        repeat (5) step();
        check_eq("bp_req", 32'(imemReq), 32'd0);
        check_eq("bp_stall", 32'(fetchStall), 32'd0);
        drv_freeze = 1'b0;
        repeat (8) step();

        // branch while a 3-cycle request to 0x8 is in flight
        fix_lat = 2;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (imemReq && imemAddr == 32'h8) found = 1'b1;
            else step();
        end
        check_eq("br_reach8", 32'(found), 32'd1);
        step();
        drv_br    = 1'b1;
        drv_baddr = 32'h100;
        step();
        drv_br = 1'b0;
        check_eq("br_hold_addr", imemAddr, 32'h8);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (!fetchStall) found = 1'b1;
            else step();
        end
        check_eq("br_out", 32'(found), 32'd1);
        check_eq("br_first_pc", PC, 32'h104);
        check_eq("br_first_ins", instruction, 32'hE000_0100);

        // branch, ready and freeze together with an occupied FIFO
        fix_lat = 0;
        repeat (6) step();
        drv_freeze = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (imemReq && q.size() == DEPTH - 1) found = 1'b1;
            else step();
        end
        check_eq("sim_setup", 32'(found), 32'd1);
        drv_br    = 1'b1;
        drv_baddr = 32'h240;
        step();
        drv_br     = 1'b0;
        drv_freeze = 1'b0;
        check_eq("sim_stall", 32'(fetchStall), 32'd1);
        check_eq("sim_req", 32'(imemReq), 32'd1);
        check_eq("sim_addr", imemAddr, 32'h240);
        repeat (4) step();

        // wrap-around redirect
        drv_br    = 1'b1;
        drv_baddr = 32'hFFFF_FFFC;
        step();
        drv_br = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (!fetchStall) found = 1'b1;
            else step();
        end
        check_eq("wrap_out", 32'(found), 32'd1);
        check_eq("wrap_pc", PC, 32'h0);
        check_eq("wrap_ins", instruction, 32'hFFFF_FFFC);
        check_eq("wrap_req", 32'(imemReq), 32'd1);
        check_eq("wrap_next", imemAddr, 32'h0);
        repeat (4) step();

        // randomized traffic with a reset in the middle
        fix_lat = -1;
        for (int i = 0; i < 3000; i++) begin
            drv_freeze = ($urandom_range(9) < 3);
            drv_br     = ($urandom_range(19) == 0);
            drv_baddr  = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(7) == 0) drv_baddr = 32'hFFFF_FFF0 + 32'($urandom_range(3) * 4);
            step();
            if (i == 1500) begin
                drv_freeze = 1'b0;
                drv_br     = 1'b0;
                do_reset();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction fetch unit that drives the IF/ID pipeline register. It owns the program counter and runs a single-outstanding request/ready handshake to instruction memory. It buffers fetched instructions in a small prefetch FIFO and presents them, with their PC+4 value, to IF/ID. It handles branch redirects and backpressure from the hazard unit.

## Interface
- DEPTH, 2, prefetch FIFO entries (≥2)
- RESET_PC, 32'h0, first fetch address after reset

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- freeze  in  1  hazard-unit stall of IF/ID; no instruction consumed this cycle
- branchTaken  in  1  redirect pulse from EXE; wins over everything except rst
- branchAddr  in  32  redirect target, word aligned
- imemReq  out  1  request to instruction memory
- imemAddr  out  32  request address, stable while imemReq=1
- imemReady  in  1  request completed; imemData valid this cycle
- imemData  in  32  returned instruction word
- PC  out  32  fetch address + 4 of FIFO head (to IF/ID PCIn)
- instruction  out  32  FIFO head word (to IF/ID instructionIn)
- fetchStall  out  1  FIFO empty; top level ORs it into the IF/ID freeze

## Operation
- Registers:
  - fetchPC: next address to request.
  - reqAddr: address of the in-flight request.
  - FIFO of {addr+4, word}.
  - FSM with states IDLE, REQ, DROP.
- imemReq = (state==REQ || state==DROP). imemAddr = reqAddr.
- Bus rule: once raised, imemReq and imemAddr hold until the imemReady cycle. A request is never withdrawn except by rst.
- pop = !freeze && !empty && !branchTaken. push = (state==REQ) && imemReady && !branchTaken.
- room = (count − pop + push) < DEPTH, evaluated on next-cycle occupancy.
- FSM transitions:
  - IDLE → REQ when room. Load reqAddr=fetchPC, then fetchPC += 4.
  - REQ, imemReady, no branch: push. Stay REQ with the next address if room, else go to IDLE.
  - REQ, branchTaken, no imemReady: go to DROP. fetchPC = branchAddr; reqAddr unchanged.
  - REQ, branchTaken, imemReady: discard the data. Go to REQ with reqAddr = branchAddr, fetchPC = branchAddr + 4.
  - DROP, imemReady: discard the data. Go to REQ at fetchPC.
  - DROP, branchTaken: update fetchPC = branchAddr; stay DROP (same cycle as imemReady: discard, REQ at the new target).
  - IDLE, branchTaken: fetchPC = branchAddr. Go to REQ at branchAddr on the next edge.
- On branchTaken, the FIFO is cleared in the same cycle.
- Empty FIFO: PC=0, instruction=0, fetchStall=1.
- Address arithmetic is 32-bit modulo 2^32; 0xFFFFFFFC + 4 = 0x0.
- Push and pop in the same cycle on a full FIFO is legal; count is unchanged.

## Timing
- While rst=0: state=IDLE, fetchPC=RESET_PC, count=0, imemReq=0, imemAddr=0, PC=0, instruction=0, fetchStall=1.
- An in-flight request is abandoned on reset; the memory model must tolerate this.
- First edge after reset release: IDLE → REQ, imemReq=1, imemAddr=RESET_PC.
- Fill latency: imemReady at edge n means the word is at the FIFO head and visible on PC/instruction after edge n (registered). fetchStall falls in the same cycle.
- Throughput: with zero-wait memory (imemReady=1 whenever imemReq=1), one instruction per cycle with no bubbles when freeze=0.
- Redirect cost: target data appears no earlier than 2 cycles after branchTaken. If a request is in flight, add its remaining latency.
- fetchStall is combinational from count only; there are no other combinational paths from inputs to PC/instruction.

## Test plan
- **Reset:** hold rst=0 with random inputs → all outputs at reset values, fetchStall=1. Release → after 1 edge, imemReq=1, imemAddr=0x0.
- **Zero-wait stream:** imemReady=1, imemData=0xE0000000|addr → PC sequence 0x4, 0x8, 0xC… one per cycle, instruction matches, fetchStall=0 after fill.
- **Backpressure:** freeze=1 for 5 cycles mid-stream → count reaches DEPTH, imemReq drops, PC/instruction held. Release → consecutive PCs continue with no loss or duplication.
- **Branch mid-request:** 3-cycle memory, branchTaken (branchAddr=0x100) one cycle after the request to 0x8 → imemAddr stays 0x8 until ready, data discarded, next request is 0x100, first output PC=0x104.
- **Simultaneous:** branchTaken, imemReady and freeze in one cycle, FIFO full → FIFO empty next cycle, fetchStall=1, next request at branchAddr.
- **Wrap:** branchAddr=0xFFFFFFFC → first output PC=0x0, next request address 0x0.
